dac_output_stage: RTL and testbench

Parametrised successor to the fixed 24-to-16-bit offset-binary DAC conversion in the synth top. It buffers multi-channel mixed frames from the voice controller in a FIFO and releases one frame per DAC sample period from an internal frame timer. Each released frame passes through a ramped master-volume gain, saturation with clip counting, and offset-binary or two's-complement formatting. It sits between voice_controller output and the DAC pins.

---
 rtl/dac_output_stage.sv | 181 ++++++++++++++++++
 tb/tb_dac_output_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_output_stage.sv
// DAC output stage: frame FIFO, frame-rate release timer, ramped master
// volume, saturation with clip counting and DAC word formatting.
module dac_output_stage #(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 2083,
  parameter int VOL_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*IN_WIDTH-1:0]    in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VOL_WIDTH-1:0]          volume_target,
  input  logic                          offset_binary,
  input  logic                          status_clear,
  output logic [NUM_CH*OUT_WIDTH-1:0]   dac_out,
  output logic                          dac_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   clip_count,
  output logic                          underrun
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = NUM_CH * IN_WIDTH;
  localparam int PW    = IN_WIDTH + VOL_WIDTH + 1;
  localparam int SHIFT = (VOL_WIDTH - 1) + (IN_WIDTH - OUT_WIDTH);
  localparam int SW    = PW - SHIFT;  // scaled width, OUT_WIDTH+2 bits
  localparam int TW    = $clog2(CLK_DIV);
  localparam int CW    = $clog2(NUM_CH + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);

  // Frame FIFO storage and pointers
  logic [FW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    level_reg, level_next;
  logic           ready_reg;
  logic           push, pop, empty, tick;
  logic [TW-1:0]  timer_reg;

  // Pipeline state
  logic                   s1_valid_reg, s2_valid_reg;
  logic [FW-1:0]          s1_frame_reg;
  logic [NUM_CH*SW-1:0]   scaled_w, s2_scaled_reg;
  logic [VOL_WIDTH-1:0]   volume_reg;
  logic [NUM_CH*OUT_WIDTH-1:0] fmt_w, dac_out_reg;
  logic                   dac_strobe_reg;
  logic [NUM_CH-1:0]      clip_w;
  logic [CW-1:0]          n_clips;
  logic [15:0]            clip_count_reg, clip_base, clip_next;
  logic [16:0]            clip_sum;
  logic                   underrun_reg;

  assign empty = (level_reg == '0);
  assign push  = in_valid && ready_reg;
  assign tick  = (timer_reg == TIMER_LAST);
  assign pop   = tick && !empty;

  assign in_ready   = ready_reg;
  assign fifo_level = level_reg;
  assign dac_out    = dac_out_reg;
  assign dac_strobe = dac_strobe_reg;
  assign clip_count = clip_count_reg;
  assign underrun   = underrun_reg;

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel
  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + (AW+1)'(1);
    else if (!push && pop)
      level_next = level_reg - (AW+1)'(1);
  end

  // FIFO write port, left without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_sample;
  end

  // FIFO pointers, level, ready flag and frame timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ready_reg  <= 1'b0;
      timer_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      ready_reg <= (level_next != (AW+1)'(FIFO_DEPTH));
      timer_reg <= tick ? '0 : timer_reg + TW'(1);
    end
  end

  // Per-channel gain, arithmetic scaling and saturation/formatting
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [IN_WIDTH-1:0]   smp;
      logic signed [PW-1:0]  prod;
      logic                  unused_low_bits;
      logic [SW-1:0]         sv;
      logic                  sat_hi, sat_lo;
      logic [OUT_WIDTH-1:0]  word;

      assign smp  = s1_frame_reg[gi*IN_WIDTH +: IN_WIDTH];
      assign prod = $signed({{(VOL_WIDTH+1){smp[IN_WIDTH-1]}}, smp})
                  * $signed({{(IN_WIDTH+1){1'b0}}, volume_reg});
      // Dropping the low bits of the product is a floor toward -inf
      assign scaled_w[gi*SW +: SW] = prod[PW-1:SHIFT];
      assign unused_low_bits = ^prod[SHIFT-1:0];

      assign sv     = s2_scaled_reg[gi*SW +: SW];
      assign sat_hi = !sv[SW-1] && (sv[SW-2:OUT_WIDTH-1] != '0);
      assign sat_lo =  sv[SW-1] && (sv[SW-2:OUT_WIDTH-1] != '1);
      assign word   = sat_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                      sat_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                               sv[OUT_WIDTH-1:0];
      assign fmt_w[gi*OUT_WIDTH +: OUT_WIDTH] =
          {word[OUT_WIDTH-1] ^ offset_binary, word[OUT_WIDTH-2:0]};
      assign clip_w[gi] = sat_hi | sat_lo;
    end
  endgenerate

  // Clip total for the frame in S3 and the saturating counter update
  always_comb begin
    n_clips = '0;
    for (int i = 0; i < NUM_CH; i++)
      n_clips = n_clips + CW'(clip_w[i]);
    clip_base = status_clear ? 16'h0000 : clip_count_reg;
    clip_sum  = {1'b0, clip_base} + 17'(n_clips);
    clip_next = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
  end

  // Three-stage release pipeline, volume ramp and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg   <= 1'b0;
      s1_frame_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_scaled_reg  <= '0;
      volume_reg     <= '0;
      dac_out_reg    <= '0;
      dac_strobe_reg <= 1'b0;
      clip_count_reg <= '0;
      underrun_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= tick;
      if (tick)
        s1_frame_reg <= pop ? mem[rd_ptr_reg] : '0;

      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_scaled_reg <= scaled_w;
        if (volume_reg < volume_target)
          volume_reg <= volume_reg + VOL_WIDTH'(1);
        else if (volume_reg > volume_target)
          volume_reg <= volume_reg - VOL_WIDTH'(1);
      end

      dac_strobe_reg <= s2_valid_reg;
      if (s2_valid_reg) begin
        dac_out_reg    <= fmt_w;
        clip_count_reg <= clip_next;
      end else if (status_clear) begin
        clip_count_reg <= '0;
      end

      if (tick && empty)
        underrun_reg <= 1'b1;
      else if (status_clear)
        underrun_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_output_stage.sv
// Self-checking bench for dac_output_stage: directed tables, FIFO and reset
// corner sequences, and randomized frames against an arithmetic model.
module tb_dac_output_stage;

  localparam int IW = 24, OW = 16, NC = 2, FD = 8, CD = 16, VW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NC*IW-1:0] in_sample = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [VW-1:0] volume_target = '0;
  logic offset_binary = 1'b1;
  logic status_clear = 1'b0;
  logic [NC*OW-1:0] dac_out;
  logic dac_strobe;
  logic [$clog2(FD):0] fifo_level;
  logic [15:0] clip_count;
  logic underrun;

  dac_output_stage #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_CH(NC),
    .FIFO_DEPTH(FD), .CLK_DIV(CD), .VOL_WIDTH(VW)
  ) dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready), .volume_target(volume_target),
    .offset_binary(offset_binary), .status_clear(status_clear),
    .dac_out(dac_out), .dac_strobe(dac_strobe), .fifo_level(fifo_level),
    .clip_count(clip_count), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int vol_m = 0;  // model of the ramped volume

  typedef struct {
    logic [47:0] frame;
    bit          ob;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("ok   %s = 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output word model: gain vol/128, drop 8 LSBs with floor, clamp, format
  function automatic logic [31:0] exp_frame(input logic [47:0] f, input int vol,
                                            input bit ob, output int nclip);
    logic [31:0] r;
    nclip = 0;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      logic [23:0] raw;
      longint s, p, q;
      raw = f[c*24 +: 24];
      s = longint'($signed(raw));
      p = s * vol;
      q = p / 32768;
      if (p < 0 && q * 32768 != p) q = q - 1;
      if (q > 32767) begin q = 32767; nclip++; end
      else if (q < -32768) begin q = -32768; nclip++; end
      if (ob) q = q + 32768;
      else if (q < 0) q = q + 65536;
      r[c*16 +: 16] = 16'(q);
    end
    return r;
  endfunction

  task automatic push(input logic [47:0] f);
    @(negedge clk);
    in_sample = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    status_clear = 1'b1;
    @(posedge clk);
    #1;
    status_clear = 1'b0;
  endtask

  // Waits for the next strobe; reports the volume that frame was scaled by
  task automatic wait_strobe(input string name, output int vol_used);
    int k;
    vol_used = vol_m;
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (dac_strobe) break;
    end
    if (k >= 40) begin
      n_total++;
      $display("FAIL %s: no dac_strobe within 40 cycles", name);
    end else begin
      vol_used = vol_m;
      if (vol_m < int'(volume_target)) vol_m++;
      else if (vol_m > int'(volume_target)) vol_m--;
    end
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] ramp_exp[6];
    logic [47:0] fq[$];
    int vu, nclip, clip_m, n_acc, n_strb;
    bit und_m;

    tbl[0] = '{48'hFEDCBA_123456, 1'b1, 32'h7EDC_9234};
    tbl[1] = '{48'hFEDCBA_123456, 1'b0, 32'hFEDC_1234};
    tbl[2] = '{48'h800000_7FFFFF, 1'b0, 32'h8000_7FFF};
    tbl[3] = '{48'h000000_000000, 1'b1, 32'h8000_8000};
    tbl[4] = '{48'hFFFF00_0000FF, 1'b0, 32'hFFFF_0000};
    tbl[5] = '{48'hFFFFFF_000180, 1'b1, 32'h7FFF_8001};
    ramp_exp = '{16'h0000, 16'h0080, 16'h0100, 16'h0180, 16'h0200, 16'h0200};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst dac_out", dac_out, 0);
    chk("rst dac_strobe", dac_strobe, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst fifo_level", fifo_level, 0);
    chk("rst clip_count", clip_count, 0);
    chk("rst underrun", underrun, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after release", in_ready, 1);

    // Underrun frame on the first tick
    wait_strobe("first strobe", vu);
    chk("underrun frame dac_out", dac_out, 32'h8000_8000);
    chk("underrun set", underrun, 1);
    @(posedge clk);
    #1;
    chk("strobe one cycle", dac_strobe, 0);
    pulse_clear();
    chk("underrun cleared", underrun, 0);

    // Volume ramp 0 -> 4 with a constant half-scale input
    volume_target = 8'd4;
    offset_binary = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push({24'h000000, 24'h400000});
      if (i == 0) chk("fifo_level after push", fifo_level, 1);
      wait_strobe("ramp4", vu);
      chk($sformatf("ramp4 ch0 #%0d", i), dac_out[15:0], ramp_exp[i]);
    end

    // Ramp to unity, then table of directed frames
    volume_target = 8'd128;
    repeat (126) wait_strobe("ramp128", vu);
    pulse_clear();
    foreach (tbl[i]) begin
      offset_binary = tbl[i].ob;
      push(tbl[i].frame);
      wait_strobe("table", vu);
      chk($sformatf("table[%0d] dac_out", i), dac_out, tbl[i].exp);
    end
    chk("table clip_count", clip_count, 0);
    chk("table underrun", underrun, 0);

    // Ramp to 255 and drive full-scale frames into saturation
    volume_target = 8'd255;
    repeat (128) wait_strobe("ramp255", vu);
    pulse_clear();
    offset_binary = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push({24'h800000, 24'h7FFFFF});
      wait_strobe("clip", vu);
      chk($sformatf("clip dac_out #%0d", i), dac_out, 32'h0000_FFFF);
      chk($sformatf("clip_count #%0d", i), clip_count, 2 * (i + 1));
    end
    pulse_clear();

    // FIFO fill with no tick in between: 9 offered, 8 accepted
    offset_binary = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      in_sample = {24'(k), 24'(k << 16)};
      in_valid = 1'b1;
      if (in_ready) begin
        fq.push_back(in_sample);
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (k == 8) begin
        chk("in_ready low when full", in_ready, 0);
        chk("fifo_level full", fifo_level, 8);
      end
    end
    in_valid = 1'b0;
    chk("frames accepted", n_acc, 8);
    for (int k = 1; k <= 9; k++) begin
      logic [47:0] f;
      wait_strobe("drain", vu);
      f = (fq.size() > 0) ? fq.pop_front() : 48'h0;
      chk($sformatf("drain frame %0d", k), dac_out, exp_frame(f, vu, 1'b0, nclip));
    end
    chk("underrun after drain", underrun, 1);

    // Randomized frames against the model
    clip_m = 0;
    und_m = 1'b0;
    for (int it = 0; it < 40; it++) begin
      bit do_push, ob;
      logic [47:0] f;
      logic [31:0] e;
      if (it == 0 || $urandom_range(0, 3) == 0) begin
        pulse_clear();
        clip_m = 0;
        und_m = 1'b0;
      end
      volume_target = 8'($urandom_range(0, 255));
      ob = 1'($urandom_range(0, 1));
      offset_binary = ob;
      do_push = ($urandom_range(0, 3) != 0);
      f = {24'($urandom), 24'($urandom)};
      if (do_push) push(f);
      else f = '0;
      wait_strobe("rand", vu);
      e = exp_frame(f, vu, ob, nclip);
      clip_m = (clip_m + nclip > 65535) ? 65535 : clip_m + nclip;
      if (!do_push) und_m = 1'b1;
      chk($sformatf("rand %0d dac_out", it), dac_out, e);
      chk($sformatf("rand %0d clip_count", it), clip_count, clip_m);
      chk($sformatf("rand %0d underrun", it), underrun, und_m);
    end

    // Reset one cycle after a tick: in-flight frame discarded, no strobe
    offset_binary = 1'b1;
    push({24'h100000, 24'h100000});
    push({24'h200000, 24'h200000});
    repeat (12) @(posedge clk);  // now in the cycle after the pop edge
    #2;
    reset = 1'b0;
    #1;
    chk("reset dac_out", dac_out, 0);
    chk("reset fifo_level", fifo_level, 0);
    n_strb = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (dac_strobe) n_strb++;
    end
    @(negedge clk);
    reset = 1'b1;
    vol_m = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (dac_strobe) n_strb++;
    end
    chk("no strobe across reset", n_strb, 0);
    chk("fifo_level after reset", fifo_level, 0);
    chk("clip_count after reset", clip_count, 0);
    wait_strobe("post-reset", vu);
    chk("post-reset dac_out", dac_out, 32'h8000_8000);
    chk("post-reset underrun", underrun, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
